// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The segment table is used only when BCD_SEG_OUT_EN is defined.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g..a} patterns indexed by digit value; codes 10..15 blank.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Number of decimal digits needed to represent 2**n - 1.
    function automatic int digits_needed(input int n);
        longint unsigned v;
        int d;
        v = (64'd1 << n) - 64'd1;
        d = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_dabble_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Optional macro BCD_SEG_OUT_EN adds an active-low seven-segment output.
module bcd_dabble_seq
    import bcd_pkg::*;
#(
    parameter int N      = 10,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N-1:0]        bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out
`ifdef BCD_SEG_OUT_EN
    ,
    output logic [7*DIGITS-1:0] seg
`endif
);

    localparam int CW = $clog2(N + 1);
    localparam int DW = 4 * DIGITS;

    if (DIGITS < digits_needed(N)) begin : g_digits_check
        $error("bcd_dabble_seq: DIGITS too small for N-bit input");
    end

    state_t          state_reg, state_next;
    logic [N-1:0]    bin_reg, bin_next;
    logic [DW-1:0]   dig_reg, dig_next;
    logic [DW-1:0]   bcd_reg, bcd_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [DW-1:0]   adj_digits;
    logic [DW+N-1:0] shifted;

    // Corrections act on the pre-shift digit values, all digits in parallel.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (dig_reg[4*gi +: 4]),
            .adj   (adj_digits[4*gi +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            bin_reg   <= '0;
            dig_reg   <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            bin_reg   <= bin_next;
            dig_reg   <= dig_next;
            bcd_reg   <= bcd_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bin_next   = bin_reg;
        dig_next   = dig_reg;
        bcd_next   = bcd_reg;
        cnt_next   = cnt_reg;
        shifted    = {adj_digits, bin_reg} << 1;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    bin_next   = bin_in;
                    dig_next   = '0;
                    cnt_next   = CW'(N);
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                bin_next = shifted[N-1:0];
                dig_next = shifted[DW+N-1:N];
                cnt_next = cnt_reg - CW'(1);
                // Last shift: publish the result as we enter DONE.
                if (cnt_reg == CW'(1)) begin
                    bcd_next   = shifted[DW+N-1:N];
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state_reg == SHIFT);
    assign done    = (state_reg == DONE);
    assign bcd_out = bcd_reg;

`ifdef BCD_SEG_OUT_EN
    logic lead_zero;

    // Zero digits above the most significant non-zero digit are blanked.
    always_comb begin
        seg       = '1;
        lead_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (bcd_reg[4*i +: 4] == 4'd0);
            if (lead_zero && (i != 0)) begin
                seg[7*i +: 7] = SEG_BLANK;
            end else begin
                seg[7*i +: 7] = SEG_TABLE[bcd_reg[4*i +: 4]];
            end
        end
    end
`else
    // Without the segment option bcd_out is the only result.
`endif

endmodule

// File: doc/bcd_dabble_seq.md
Name: bcd_dabble_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one bit per clock. It sits directly upstream of the per-digit seven-segment decoders. It takes the switch value (bin_in) on a start handshake and produces packed BCD digits (units in the low nibble) with a one-cycle done pulse. It replaces the purely combinational conversion path so that wider inputs close timing.

Parameters:
N, 10, width of the binary input
DIGITS, 4, number of BCD output digits; must satisfy 10**DIGITS > 2**N - 1 (checked by elaboration assertion)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion of bin_in; sampled when busy=0
bin_in  input  N  binary value to convert; captured on accepted start only
busy  output  1  high while conversion in progress (state SHIFT)
done  output  1  one-cycle pulse: bcd_out updated this cycle
bcd_out  output  4*DIGITS  packed BCD result, [3:0]=units, [7:4]=tens, ...; held until next done

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset state: state=IDLE, busy=0, done=0, bcd_out=0, internal shift/digit registers=0, bit counter=0.
- FSM has three states: IDLE, SHIFT and DONE.
  - IDLE: on start=1, capture bin_in into the shift register, clear the digit registers, load the counter with N, and go to SHIFT.
  - SHIFT: each cycle, for every digit >= 5 add 3 (correction uses pre-shift values), then shift {digits, binreg} left by 1 and decrement the counter. When the counter reaches 1 (last shift), go to DONE.
  - DONE: bcd_out holds the final digits and done=1 for exactly this cycle. If start=1, behave as in IDLE (capture and go to SHIFT), allowing back-to-back conversions. Otherwise go to IDLE.
- busy = (state==SHIFT). done = (state==DONE). Both are registered, with no combinational path from start.
- Latency: start accepted at edge k -> done=1 and bcd_out valid in the cycle after edge k+N (N+1 cycles). Throughput is one conversion per N+1 cycles.
- start while busy=1 is ignored and not queued. Changes to bin_in after capture have no effect.
- bcd_out changes only on entry to DONE; intermediate digits are never visible.
- Digit correction is 4-bit: digit+3 for digit in 5..9. Digits never exceed 9 after a shift.
- Reset asserted mid-conversion: immediate return to reset values, partial result discarded, no done pulse.
- Value 0 converts normally (N shifts, result 0). Counter width is $clog2(N+1).

Optional Feature:
BCD_SEG_OUT_EN
- Defined: adds output seg [7*DIGITS-1:0], active-low segments {g..a} per digit, decoded combinationally from registered bcd_out. Leading zeros are blanked (all 1s) except the units digit.
- Undefined: the seg port and decoder are absent, and bcd_out is the only result.

Decomposition:
- bcd_pkg holds the state enum typedef (IDLE/SHIFT/DONE), the 7-bit segment pattern constant table for 0-9 plus BLANK, and a function digits_needed(N) for the elaboration check.
- Sub-module bcd_digit_adj: 4-bit in/out, combinational add-3-if->=5 cell, instantiated DIGITS times via generate.

Test Plan:
- Reset, then start with bin_in=0 -> done exactly 11 cycles after the start edge, bcd_out=16'h0000, busy high for 10 cycles.
- bin_in=1023 -> bcd_out=16'h1023; bin_in=999 -> 16'h0999; bin_in=512 -> 16'h0512.
- Start with 345, then pulse start with 678 at cycle 3 while busy -> second start ignored, bcd_out=16'h0345, single done pulse.
- Back-to-back: start held through the DONE cycle with bin_in=100 then 200 -> done pulses 11 cycles apart, results 16'h0100 then 16'h0200.
- Assert rst_n=0 at cycle 5 of a conversion of 777 -> bcd_out=0, busy=0, no done. After release, a fresh start with 777 -> 16'h0777.
- Random sweep of 1000 values in 0..1023 compared against a $floor/modulo reference model. With BCD_SEG_OUT_EN, input 7 -> upper three digits blank (7'h7F), units=7'b1111000.
